// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one signed MAC, circular sample buffer, writable coefficient RAM.
// Define FIR_SAT_EN to clamp the output to the OUT_W signed range; otherwise the output wraps.
module fir_serial_mac #(
    parameter int TAPS   = 401,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_sample,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_sample,
    output logic                       busy
);
    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam logic [ACC_W:0] RND = ((ACC_W+1)'(1) << SHIFT) >> 1;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t state, state_next;

    logic [AW-1:0]             wp, rd, k;
    logic [AW:0]               fill;
    logic                      drain_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic [DATA_W-1:0]         samp_mem [TAPS];
    logic [COEF_W-1:0]         coef_mem [TAPS];
    logic [DATA_W-1:0]         samp_q;
    logic [COEF_W-1:0]         coef_q;
    logic                      tap_en_q;
    logic signed [PW-1:0]      prod;
    logic                      accept, coef_wr, last_tap;
    logic signed [ACC_W:0]     rounded, shifted;
    logic [OUT_W-1:0]          out_next;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign coef_wr   = coef_we && (state == IDLE) && ({1'b0, coef_addr} < (AW+1)'(TAPS));
    assign last_tap  = (k == AW'(TAPS-1));

    assign prod = $signed({{COEF_W{samp_q[DATA_W-1]}}, samp_q})
                * $signed({{DATA_W{coef_q[COEF_W-1]}}, coef_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = MAC;
            MAC:     if (last_tap)  state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Storage is deliberately left out of reset so coefficients survive it.
    always_ff @(posedge clk) begin
        if (accept)  samp_mem[wp]        <= in_sample;
        if (coef_wr) coef_mem[coef_addr] <= coef_data;
        samp_q <= samp_mem[rd];
        coef_q <= coef_mem[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp         <= '0;
            rd         <= '0;
            k          <= '0;
            fill       <= '0;
            drain_cnt  <= 1'b0;
            acc        <= '0;
            tap_en_q   <= 1'b0;
            out_sample <= '0;
        end else begin
            // Taps beyond the fill level are masked so stale buffer data never contributes.
            tap_en_q <= (state == MAC) && ({1'b0, k} < fill);
            if (tap_en_q)
                acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            case (state)
                IDLE: begin
                    if (accept) begin
                        wp   <= (wp == AW'(TAPS-1)) ? '0 : wp + AW'(1);
                        fill <= (fill == (AW+1)'(TAPS)) ? fill : fill + (AW+1)'(1);
                        rd   <= wp;
                        k    <= '0;
                        acc  <= '0;
                    end
                end
                MAC: begin
                    k         <= k + AW'(1);
                    rd        <= (rd == '0) ? AW'(TAPS-1) : rd - AW'(1);
                    drain_cnt <= 1'b0;
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt)
                        out_sample <= out_next;
                end
                default: ;
            endcase
        end
    end

    // Round half up, then shift arithmetically.
    always_comb begin
        rounded = {acc[ACC_W-1], acc} + $signed(RND);
        shifted = rounded >>> SHIFT;
        out_next = OUT_W'(shifted);
`ifdef FIR_SAT_EN
        if (shifted > $signed((ACC_W+1)'({(OUT_W-1){1'b1}})))
            out_next = {1'b0, {(OUT_W-1){1'b1}}};
        else if (shifted < $signed(~(ACC_W+1)'({(OUT_W-1){1'b1}})))
            out_next = {1'b1, {(OUT_W-1){1'b0}}};
`else
        out_next = OUT_W'(shifted);
`endif
    end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: one 4-tap instance with SHIFT=0 and one with SHIFT=15 for rounding.
module tb_fir_serial_mac;
    localparam int TAPS = 4;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] in_sample = '0;
    logic [1:0] coef_addr = '0;
    logic [CW-1:0] coef_data = '0;
    logic out_ready = 1'b0;
    logic in_valid_a = 1'b0, coef_we_a = 1'b0;
    logic in_valid_b = 1'b0, coef_we_b = 1'b0;
    logic in_ready_a, out_valid_a, busy_a;
    logic in_ready_b, out_valid_b, busy_b;
    logic [OW-1:0] out_sample_a, out_sample_b;

    fir_serial_mac #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_sample(in_sample), .coef_we(coef_we_a), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sample(out_sample_a), .busy(busy_a));

    fir_serial_mac #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(15)) dut_rnd (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_sample(in_sample), .coef_we(coef_we_b), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sample(out_sample_b), .busy(busy_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [CW-1:0] coef_m [TAPS];
    logic signed [DW-1:0] hist [TAPS];
    int fill_m = 0;
    logic [OW-1:0] qa[$];
    logic [OW-1:0] qb[$];
    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] reduce(input longint sum, input int sh);
        longint r;
        r = (sum + ((longint'(1) << sh) >>> 1)) >>> sh;
`ifdef FIR_SAT_EN
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
`endif
        return r[OW-1:0];
    endfunction

    // Reference FIR for the SHIFT=0 instance: newest sample at hist[0].
    task automatic model_accept(input logic [DW-1:0] x);
        longint sum = 0;
        for (int i = TAPS-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        if (fill_m < TAPS) fill_m++;
        for (int i = 0; i < fill_m; i++) sum += longint'(coef_m[i]) * longint'(hist[i]);
        qa.push_back(reduce(sum, 0));
    endtask

    task automatic write_coef(input int d, input int addr, input logic [CW-1:0] data);
        @(negedge clk);
        coef_addr = addr[1:0];
        coef_data = data;
        if (d == 0) coef_we_a = 1'b1; else coef_we_b = 1'b1;
        @(negedge clk);
        coef_we_a = 1'b0;
        coef_we_b = 1'b0;
        if (d == 0) coef_m[addr] = data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fill_m = 0;
        qa.delete();
        qb.delete();
    endtask

    task automatic applyStimulus(input int d, input logic [DW-1:0] x);
        int n = 0;
        @(negedge clk);
        while (((d == 0) ? in_ready_a : in_ready_b) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", (d == 0) ? in_ready_a : in_ready_b, 1);
        in_sample = x;
        if (d == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        acc_cyc = cyc;
        if (d == 0) model_accept(x);
    endtask

    task automatic checkOutput(input int d, input string tag);
        int n = 0;
        logic [OW-1:0] exp;
        out_ready = 1'b1;
        while (((d == 0) ? out_valid_a : out_valid_b) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (((d == 0) ? out_valid_a : out_valid_b) !== 1'b1) begin
            check({tag, "_timeout"}, (d == 0) ? out_valid_a : out_valid_b, 1);
        end else begin
            exp = (d == 0) ? qa.pop_front() : qb.pop_front();
            check(tag, (d == 0) ? out_sample_a : out_sample_b, exp);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [OW-1:0] first, exp;
        logic stable, seen;
        int n;
        logic [DW-1:0] impulse [5];
        impulse[0] = 16'd1; impulse[1] = 16'd0; impulse[2] = 16'd0;
        impulse[3] = 16'd0; impulse[4] = 16'd0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready_a, 1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_sample", out_sample_a, 0);
        check("rst_busy", busy_a, 0);
        rst = 1'b0;

        for (int i = 0; i < TAPS; i++) write_coef(1, i, (i == 0) ? 16'd1 : 16'd0);

        $display("[TB] impulse response");
        for (int i = 0; i < TAPS; i++) write_coef(0, i, 16'(i + 1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, impulse[i]);
            checkOutput(0, $sformatf("impulse_%0d", i));
        end

        $display("[TB] fill tracking after reset");
        for (int i = 0; i < TAPS; i++) write_coef(0, i, 16'd1);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 16'd100);
            checkOutput(0, "pollute");
        end
        do_reset();
        applyStimulus(0, 16'd5);
        checkOutput(0, "fill_first");
        applyStimulus(0, 16'd7);
        checkOutput(0, "fill_second");

        $display("[TB] latency and backpressure");
        applyStimulus(0, 16'd3);
        n = 0;
        while (out_valid_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", cyc - acc_cyc, TAPS + 2);
        first = out_sample_a;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_sample_a !== first || out_valid_a !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        exp = qa.pop_front();
        check("bp_value", out_sample_a, exp);
        check("bp_in_ready", in_ready_a, 0);
        check("bp_busy", busy_a, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready", in_ready_a, 1);
        check("post_out_valid", out_valid_a, 0);

        $display("[TB] coefficient write while busy");
        applyStimulus(0, 16'd2);
        coef_addr = 2'd0;
        coef_data = 16'd100;
        coef_we_a = 1'b1;
        @(negedge clk);
        coef_we_a = 1'b0;
        checkOutput(0, "busy_write_same");
        applyStimulus(0, 16'd1);
        checkOutput(0, "busy_write_next");

        $display("[TB] coefficient write and accept in one cycle");
        @(negedge clk);
        check("wr_acc_in_ready", in_ready_a, 1);
        coef_addr = 2'd1;
        coef_data = 16'd9;
        coef_we_a = 1'b1;
        in_sample = 16'd4;
        in_valid_a = 1'b1;
        @(negedge clk);
        coef_we_a = 1'b0;
        in_valid_a = 1'b0;
        coef_m[1] = 16'd9;
        model_accept(16'd4);
        checkOutput(0, "write_and_accept");

        $display("[TB] output overflow");
        for (int i = 0; i < TAPS; i++) write_coef(0, i, 16'h7FFF);
        do_reset();
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 16'h7FFF);
            checkOutput(0, $sformatf("overflow_%0d", i));
        end

        $display("[TB] reset during MAC");
        applyStimulus(0, 16'd5);
        rst = 1'b1;
        fill_m = 0;
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_a !== 1'b0) seen = 1'b1;
        end
        check("rst_mid_no_out_valid", seen, 0);
        check("rst_mid_in_ready", in_ready_a, 1);
        check("rst_mid_busy", busy_a, 0);
        applyStimulus(0, 16'd6);
        checkOutput(0, "after_rst_mid");

        $display("[TB] rounding");
        do_reset();
        qb.push_back(16'h0001);
        applyStimulus(1, 16'h4000);
        checkOutput(1, "round_half_up");
        write_coef(1, 0, 16'h4000);
        qb.push_back(16'h2000);
        applyStimulus(1, 16'h4000);
        checkOutput(1, "round_scale");
        write_coef(1, 0, 16'h0001);
        qb.push_back(16'h0000);
        applyStimulus(1, 16'hC000);
        checkOutput(1, "round_neg_half");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
